// File: rtl/fifo_pkg.sv
// Shared sizing helpers and parameter checks for the single-clock FIFO.
package fifo_pkg;

  localparam int DEF_WIDTH = 32'sd8;
  localparam int DEF_DEPTH = 32'sd16;

  function automatic int addr_width(input int depth);
    return (depth > 32'sd1) ? $clog2(depth) : 32'sd1;
  endfunction

  function automatic int ptr_width(input int depth);
    return addr_width(depth) + 32'sd1;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 32'sd2) && ((v & (v - 32'sd1)) == 32'sd0);
  endfunction

  function automatic bit levels_ok(input int depth, input int af, input int ae);
    return (af >= 32'sd1) && (af <= depth) && (ae >= 32'sd0) && (ae <= depth - 32'sd1);
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Handshake, data and status bundle between the FIFO and its producer/consumer.
interface sync_fifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = fifo_pkg::ptr_width(DEPTH);

  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full_flag;
  logic             empty_flag;
  logic             almost_full;
  logic             almost_empty;
  logic [CW-1:0]    data_count;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full_flag, empty_flag, almost_full, almost_empty,
           data_count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full_flag, empty_flag, almost_full, almost_empty,
           data_count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port RAM with synchronous write and registered read; the array itself is never reset.
module fifo_ram import fifo_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] rdata_d;

  // Storage array write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read data holds unless a pop is performed
  always_comb begin
    rdata_d = re ? mem_q[raddr] : rdata_q;
  end

  // Output data register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata_q <= {WIDTH{1'b0}};
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, programmable thresholds, synchronous flush
// and registered overflow/underflow pulses.
module sync_fifo import fifo_pkg::*; #(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input logic        clk,
  input logic        rstn,
  sync_fifo_if.slave bus
);

  localparam int AW = addr_width(DEPTH);
  localparam int CW = ptr_width(DEPTH);

  typedef logic [AW:0]   ptr_t;
  typedef logic [CW-1:0] cnt_t;

  localparam ptr_t PTR_ONE = ptr_t'(32'd1);
  localparam cnt_t CNT_ONE = cnt_t'(32'd1);
  localparam cnt_t AF_C    = cnt_t'(AF_LEVEL);
  localparam cnt_t AE_C    = cnt_t'(AE_LEVEL);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end
  if (!levels_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
    $error("sync_fifo: AF_LEVEL or AE_LEVEL out of range");
  end

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t count_q, count_d;
  logic full_q, full_d;
  logic empty_q, empty_d;
  logic af_q, af_d;
  logic ae_q, ae_d;
  logic rd_valid_q, rd_valid_d;
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;
  logic acc_wr_s;
  logic acc_rd_s;

  // Acceptance, pointer/count update and post-update flag derivation
  always_comb begin
    acc_wr_s = bus.wr_en & ~full_q & ~bus.flush;
    acc_rd_s = bus.rd_en & ~empty_q & ~bus.flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = acc_wr_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      rd_ptr_d = acc_rd_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      case ({acc_wr_s, acc_rd_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    // Wrap bit distinguishes full from empty when the addresses coincide
    empty_d    = (wr_ptr_d == rd_ptr_d);
    full_d     = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
    af_d       = (count_d >= AF_C);
    ae_d       = (count_d <= AE_C);
    rd_valid_d = acc_rd_s;
    ovf_d      = bus.wr_en & full_q & ~bus.flush;
    udf_d      = bus.rd_en & empty_q & ~bus.flush;
  end

  // Pointer, count, flag and pulse registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ae_q       <= 1'b1;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      af_q       <= af_d;
      ae_q       <= ae_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rstn  (rstn),
    .we    (acc_wr_s),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (bus.wr_data),
    .re    (acc_rd_s),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (bus.rd_data)
  );

  assign bus.rd_valid     = rd_valid_q;
  assign bus.full_flag    = full_q;
  assign bus.empty_flag   = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.data_count   = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed plus randomized bench for sync_fifo, checked against a queue-based reference model.
module tb_sync_fifo;

  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AF = 6;
  localparam int AE = 2;

  logic clk = 1'b0;
  logic rstn;

  always #5 clk = ~clk;

  sync_fifo_if #(.WIDTH(W), .DEPTH(D)) bus();

  sync_fifo #(
    .WIDTH    (W),
    .DEPTH    (D),
    .AF_LEVEL (AF),
    .AE_LEVEL (AE)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [W-1:0] q[$];
  logic [W-1:0] exp_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's occupancy and expected pulses
  task automatic check_state(input string ctx, input logic e_val, input logic e_ovf, input logic e_udf);
    int sz;
    sz = q.size();
    chk({ctx, ".count"},     32'(bus.data_count),   32'(sz));
    chk({ctx, ".full"},      32'(bus.full_flag),    32'(sz == D));
    chk({ctx, ".empty"},     32'(bus.empty_flag),   32'(sz == 0));
    chk({ctx, ".afull"},     32'(bus.almost_full),  32'(sz >= AF));
    chk({ctx, ".aempty"},    32'(bus.almost_empty), 32'(sz <= AE));
    chk({ctx, ".rd_valid"},  32'(bus.rd_valid),     32'(e_val));
    chk({ctx, ".rd_data"},   32'(bus.rd_data),      32'(exp_rd));
    chk({ctx, ".overflow"},  32'(bus.overflow),     32'(e_ovf));
    chk({ctx, ".underflow"}, 32'(bus.underflow),    32'(e_udf));
  endtask

  // One clock of stimulus followed by model update and full output check
  task automatic step(input string ctx, input logic wr, input logic [W-1:0] d,
                      input logic rd, input logic fl);
    int   sz;
    logic aw, ar, e_ovf, e_udf;
    sz    = q.size();
    aw    = wr && (sz != D) && !fl;
    ar    = rd && (sz != 0) && !fl;
    e_ovf = wr && (sz == D) && !fl;
    e_udf = rd && (sz == 0) && !fl;
    bus.wr_en   = wr;
    bus.wr_data = d;
    bus.rd_en   = rd;
    bus.flush   = fl;
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
    end else begin
      if (ar) exp_rd = q.pop_front();
      if (aw) q.push_back(d);
    end
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.flush = 1'b0;
    check_state(ctx, ar, e_ovf, e_udf);
  endtask

  initial begin
    logic [W-1:0] rnd_d;
    logic         rnd_w, rnd_r, rnd_f;
    int           pw;

    rstn        = 1'b0;
    bus.flush   = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_data = '0;
    exp_rd      = '0;
    #12;
    check_state("reset", 1'b0, 1'b0, 1'b0);
    rstn = 1'b1;

    // Fill to full, then one rejected write
    for (int i = 1; i <= 8; i++) step("fill", 1'b1, W'(i), 1'b0, 1'b0);
    step("fill_ovf", 1'b1, 8'hEE, 1'b0, 1'b0);
    step("fill_hold", 1'b0, 8'h00, 1'b0, 1'b0);

    // Drain in order, then one rejected read
    for (int i = 0; i < 8; i++) step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    step("drain_udf", 1'b0, 8'h00, 1'b1, 1'b0);

    // Simultaneous on empty: write wins, read rejected
    step("empty_rw", 1'b1, 8'h5A, 1'b1, 1'b0);
    step("empty_rw_rd", 1'b0, 8'h00, 1'b1, 1'b0);

    // Simultaneous on full: read wins, written word dropped
    for (int i = 0; i < 8; i++) step("refill", 1'b1, W'(8'h30 + i), 1'b0, 1'b0);
    step("full_rw", 1'b1, 8'h99, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step("full_rw_drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // Wrap-around streaming with one word resident
    step("wrap_prime", 1'b1, 8'd0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step("wrap", 1'b1, W'(i + 1), 1'b1, 1'b0);
    step("wrap_tail", 1'b0, 8'h00, 1'b1, 1'b0);

    // Flush with write and read requested at the same time
    for (int i = 0; i < 5; i++) step("pre_flush", 1'b1, W'(8'h60 + i), 1'b0, 1'b0);
    step("flush", 1'b1, 8'h77, 1'b1, 1'b1);
    step("post_flush_wr", 1'b1, 8'hAA, 1'b0, 1'b0);
    step("post_flush_rd", 1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset between edges with four words stored
    for (int i = 0; i < 4; i++) step("pre_rst", 1'b1, W'(8'hC0 + i), 1'b0, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    q.delete();
    exp_rd = '0;
    check_state("async_rst", 1'b0, 1'b0, 1'b0);
    #3;
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) step("post_rst_wr", 1'b1, W'(8'hD0 + i), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("post_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic, biased toward filling then draining
    for (int i = 0; i < 400; i++) begin
      pw    = ((i / 50) % 2 == 0) ? 75 : 25;
      rnd_w = ($urandom_range(0, 99) < pw);
      rnd_r = ($urandom_range(0, 99) < (100 - pw));
      rnd_f = ($urandom_range(0, 63) == 0);
      rnd_d = W'($urandom);
      step("random", rnd_w, rnd_d, rnd_r, rnd_f);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock, parametrised FIFO that follows the two-clock FIFO in the same buffering path. It is used wherever producer and consumer share one clock. It keeps the rd_valid / full_flag / empty_flag signalling of the two-clock FIFO. It adds the following, which the two-clock FIFO does not have:
- programmable almost-full and almost-empty thresholds;
- an exact occupancy count;
- a synchronous flush;
- overflow and underflow error pulses.

## Interface
- WIDTH, 8, data word width (≥1)
- DEPTH, 16, number of entries; must be a power of two and ≥2
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL (range 1..DEPTH)
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL (range 0..DEPTH-1)
- clk  in  1  single clock; all logic on the rising edge
- rstn  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear; has priority over wr_en and rd_en
- wr_en  in  1  write request
- wr_data  in  WIDTH  write data
- rd_en  in  1  read request
- rd_data  out  WIDTH  registered read data
- rd_valid  out  1  rd_data holds a newly popped word this cycle
- full_flag  out  1  count == DEPTH
- empty_flag  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- data_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow  out  1  one-cycle pulse: write rejected
- underflow  out  1  one-cycle pulse: read rejected

## Operation
- Pointers: wr_ptr and rd_ptr are AW+1 bits wide, where AW=$clog2(DEPTH). The MSB is the wrap bit. Memory is addressed by the low AW bits, which wrap from DEPTH-1 to 0.
- Full and empty: empty when the pointers are equal. Full when the low bits are equal and the MSBs differ.
- Write acceptance: a write is accepted when wr_en && !full_flag && !flush.
- Read acceptance: a read is accepted when rd_en && !empty_flag && !flush.
- Flags used for acceptance: decisions use the flags registered at the start of the cycle, never the combinational next state.
- Simultaneous read and write:
  - When full, the read is accepted and the write is rejected (overflow=1). Count goes DEPTH → DEPTH-1.
  - When empty, the write is accepted and the read is rejected (underflow=1). Count goes 0 → 1.
  - Otherwise both are accepted and the count is unchanged.
- Count: data_count_next = data_count + acc_wr − acc_rd. No saturation is needed because the flags prevent it.
- Flush: sets both pointers and data_count to 0, and sets rd_valid=0. It does not raise overflow or underflow. rd_data holds its value. Memory contents are not cleared.
- Error pulses: overflow = wr_en && full_flag && !flush; underflow = rd_en && empty_flag && !flush. These are registered and last one cycle per offending cycle. They do not change any state.
- Data order: strict first-in first-out, including across pointer wrap.

## Timing
- Reset values: rd_data=0, rd_valid=0, full_flag=0, empty_flag=1, almost_full=0, almost_empty=1, data_count=0, overflow=0, underflow=0, both pointers 0.
- Reset is asynchronous: asserting rstn mid-operation drops everything to the reset values immediately.
- Flag and count timing: all flags and data_count are registered and reflect post-update occupancy from the edge that performs the update.
- Write latency: a write accepted at edge N makes empty_flag=0 after edge N. The word can be read by a read accepted at edge N+1.
- Read latency: a read accepted at edge N drives rd_data and rd_valid=1 after edge N. rd_valid drops after edge N+1 unless another read is accepted at that edge.
- Back-to-back operation: one write and one read per cycle, sustained, with no bubbles.
- Threshold flags: almost_full and almost_empty update on the same edge as data_count.

## Structure
- Shared package fifo_pkg holds:
  - function clog2-based AW and pointer width;
  - a typedef for the pointer (logic [AW:0]);
  - elaboration checks (assertion) that DEPTH is a power of two and that AF_LEVEL/AE_LEVEL are in range.
- Sub-module fifo_ram: simple dual-port RAM, DEPTH×WIDTH, with a synchronous write port and a synchronous read port. It produces the registered rd_data. No reset is applied to the array.
- Top level sync_fifo contains the pointers, counter, flags, error pulses and flush.

## Test plan
- Reset and fill (DEPTH=8, AF=6, AE=2): write 8 words 0x01..0x08 back-to-back.
  - almost_empty drops after the 3rd write.
  - almost_full rises after the 6th write.
  - full_flag=1 and data_count=8 after the 8th write.
  - A 9th wr_en gives overflow=1 for one cycle and data_count stays 8.
- Drain: 8 reads on a full FIFO return 0x01..0x08 in order, each with rd_valid=1 one cycle after its read. After the last read, empty_flag=1. A further rd_en gives underflow=1 with rd_valid=0.
- Simultaneous read and write:
  - When full, data_count goes 8→7, overflow=1, and the rejected word is never returned.
  - When empty, data_count goes 0→1, underflow=1, and the next read returns the written word.
- Wrap-around: run 20 cycles of continuous write and read with data 0..19. The output sequence is exactly 0..19, data_count stays at 1 throughout, and there are no error pulses.
- Flush: with 5 words stored, assert flush together with wr_en and rd_en. Next cycle: data_count=0, empty_flag=1, rd_valid=0, no error pulses. A subsequent write of 0xAA then a read returns 0xAA.
- Asynchronous reset mid-operation: drop rstn between clock edges while data_count=4. All outputs take their reset values immediately. After release, first-in first-out operation resumes from an empty FIFO.
